// File: rtl/duty_ramp_if.sv
// Request channel of duty_ramp: a duty magnitude plus motor direction offered
// under a valid/ready handshake.
interface duty_ramp_if #(
    parameter int CTR_LEN = 10
);
    logic [CTR_LEN-1:0] target;
    logic               target_dir;
    logic               target_valid;
    logic               target_ready;

    modport master (
        output target,
        output target_dir,
        output target_valid,
        input  target_ready
    );

    modport slave (
        input  target,
        input  target_dir,
        input  target_valid,
        output target_ready
    );
endinterface

// File: rtl/duty_ramp.sv
// Slew-limited PWM duty ramp with direction reversal through zero duty.
// Define DUTY_RAMP_DEADTIME_EN to hold zero duty for DEAD_PERIODS ticks before a flip.
module duty_ramp #(
    parameter int CTR_LEN      = 10,
    parameter int STEP         = 8,
    parameter int DEAD_PERIODS = 4
) (
    input  logic               clk,
    input  logic               rst,
    duty_ramp_if.slave         bus,
    input  logic               estop,
    output logic [CTR_LEN-1:0] compare,
    output logic               dir,
    output logic               busy,
    output logic               period_tick
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HOLD,
        ST_REVERSE,
        ST_DEAD
    } state_t;

    localparam logic [CTR_LEN:0]   STEP_EXT = (CTR_LEN+1)'(STEP);
    localparam logic [CTR_LEN-1:0] STEP_N   = CTR_LEN'(STEP);
    localparam logic [CTR_LEN-1:0] CNT_PRE  = {{(CTR_LEN-1){1'b1}}, 1'b0};

    state_t             r_state;
    logic [CTR_LEN-1:0] r_cnt;
    logic               r_tick;
    logic [CTR_LEN-1:0] r_compare;
    logic               r_dir;
    logic [CTR_LEN-1:0] r_tgt;
    logic               r_tdir;

`ifdef DUTY_RAMP_DEADTIME_EN
    localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_PERIODS - 1);
    logic [DW-1:0] r_dead_cnt;
`else
    localparam int unused_dead_periods = DEAD_PERIODS;
`endif

    logic               w_accept;
    logic [CTR_LEN-1:0] w_goal;
    logic [CTR_LEN:0]   w_cmp_ext;
    logic [CTR_LEN:0]   w_goal_ext;
    logic [CTR_LEN:0]   w_up;
    logic [CTR_LEN:0]   w_dn_lim;
    logic [CTR_LEN-1:0] w_slew;

    assign bus.target_ready = !estop &&
        (r_state == ST_IDLE || r_state == ST_TRACK || r_state == ST_HOLD);
    assign w_accept    = bus.target_valid && bus.target_ready;
    assign compare     = r_compare;
    assign dir         = r_dir;
    assign period_tick = r_tick;
    assign busy        = (r_state == ST_TRACK) || (r_state == ST_REVERSE) ||
                         (r_state == ST_DEAD);

    // One extra bit keeps compare+STEP and goal+STEP from wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_goal     = (r_state == ST_TRACK) ? r_tgt : '0;
        w_cmp_ext  = {1'b0, r_compare};
        w_goal_ext = {1'b0, w_goal};
        w_up       = w_cmp_ext + STEP_EXT;
        w_dn_lim   = w_goal_ext + STEP_EXT;
        w_slew     = r_compare;
        if (w_cmp_ext < w_goal_ext) begin
            w_slew = (w_up >= w_goal_ext) ? w_goal : w_up[CTR_LEN-1:0];
        end else if (w_cmp_ext > w_goal_ext) begin
            w_slew = (w_cmp_ext >= w_dn_lim) ? (r_compare - STEP_N) : w_goal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_compare <= '0;
            r_dir     <= 1'b0;
            r_tgt     <= '0;
            r_tdir    <= 1'b0;
`ifdef DUTY_RAMP_DEADTIME_EN
            r_dead_cnt <= '0;
`endif
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= (r_cnt == CNT_PRE);
            if (estop) begin
                r_compare <= '0;
                r_tgt     <= '0;
                r_state   <= ST_IDLE;
`ifdef DUTY_RAMP_DEADTIME_EN
                r_dead_cnt <= '0;
`endif
            end else begin
                if (r_tick) begin
                    case (r_state)
                        ST_TRACK: begin
                            r_compare <= w_slew;
                            if (w_slew == r_tgt) begin
                                r_state <= (r_tgt == '0) ? ST_IDLE : ST_HOLD;
                            end
                        end
                        ST_REVERSE: begin
                            r_compare <= w_slew;
                            if (w_slew == '0) begin
`ifdef DUTY_RAMP_DEADTIME_EN
                                r_state    <= ST_DEAD;
                                r_dead_cnt <= '0;
`else
                                r_dir   <= r_tdir;
                                r_state <= ST_TRACK;
`endif
                            end
                        end
`ifdef DUTY_RAMP_DEADTIME_EN
                        ST_DEAD: begin
                            if (r_dead_cnt == DEAD_LAST) begin
                                r_dead_cnt <= '0;
                                r_dir      <= r_tdir;
                                r_state    <= ST_TRACK;
                            end else begin
                                r_dead_cnt <= r_dead_cnt + 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
                // NOTE: non-blocking assignments let this later acceptance override the
                // tick's state choice while the tick still slewed toward the old goal.
                if (w_accept) begin
                    r_tgt  <= bus.target;
                    r_tdir <= bus.target_dir;
                    if (bus.target_dir == r_dir || r_compare == '0) begin
                        r_dir   <= bus.target_dir;
                        r_state <= ST_TRACK;
                    end else begin
                        r_state <= ST_REVERSE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp at CTR_LEN=4, STEP=3, DEAD_PERIODS=2; expectations
// follow DUTY_RAMP_DEADTIME_EN when it is defined.
module tb_duty_ramp;

    localparam int CTR_LEN = 4;

    logic               clk;
    logic               rst;
    logic               estop;
    logic [CTR_LEN-1:0] compare;
    logic               dir;
    logic               busy;
    logic               period_tick;

    int n_checks;
    int n_errors;

    duty_ramp_if #(.CTR_LEN(CTR_LEN)) bus ();

    duty_ramp #(
        .CTR_LEN      (CTR_LEN),
        .STEP         (3),
        .DEAD_PERIODS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .estop       (estop),
        .compare     (compare),
        .dir         (dir),
        .busy        (busy),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next period_tick edge; returns at posedge+1.
    task automatic next_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("tick_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CTR_LEN-1:0] t, input logic d);
        bus.target       = t;
        bus.target_dir   = d;
        bus.target_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.target_valid = 1'b0;
    endtask

    task automatic send_on_tick(input logic [CTR_LEN-1:0] t, input logic d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("tick_accept_timeout", 32'd0, 32'd1);
        bus.target       = t;
        bus.target_dir   = d;
        bus.target_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.target_valid = 1'b0;
    endtask

    task automatic tick_expect(input string tag, input logic [CTR_LEN-1:0] exp);
        next_tick();
        check(tag, 32'(compare), 32'(exp));
    endtask

    initial begin
        int gap;
        bit seen;
        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b0;
        estop            = 1'b0;
        bus.target       = '0;
        bus.target_dir   = 1'b0;
        bus.target_valid = 1'b0;

        #3;
        check("rst_compare", 32'(compare), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_tick", 32'(period_tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.target_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Ramp up from reset
        next_tick();
        send(4'd10, 1'b0);
        check("up_busy", 32'(busy), 32'd1);
        tick_expect("up_3", 4'd3);
        tick_expect("up_6", 4'd6);
        tick_expect("up_9", 4'd9);
        tick_expect("up_10", 4'd10);
        check("up_hold_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("tick_one_cycle", 32'(period_tick), 32'd0);
        @(posedge clk);
        #1;

        // Ramp down within HOLD
        next_tick();
        send(4'd2, 1'b0);
        tick_expect("dn_7", 4'd7);
        tick_expect("dn_4", 4'd4);
        tick_expect("dn_2", 4'd2);
        check("dn_hold_busy", 32'(busy), 32'd0);

        next_tick();
        send(4'd9, 1'b0);
        tick_expect("pre_5", 4'd5);
        tick_expect("pre_8", 4'd8);
        tick_expect("pre_9", 4'd9);

        // Reversal
        next_tick();
        send(4'd5, 1'b1);
        check("rev_ready", 32'(bus.target_ready), 32'd0);
        check("rev_dir_kept", 32'(dir), 32'd0);
        tick_expect("rev_6", 4'd6);
        tick_expect("rev_3", 4'd3);
        tick_expect("rev_0", 4'd0);
`ifdef DUTY_RAMP_DEADTIME_EN
        check("rev_zero_dir", 32'(dir), 32'd0);
        check("rev_zero_ready", 32'(bus.target_ready), 32'd0);
        tick_expect("dead_1", 4'd0);
        check("dead_1_dir", 32'(dir), 32'd0);
        tick_expect("dead_2", 4'd0);
        check("dead_2_dir", 32'(dir), 32'd1);
`else
        check("rev_zero_dir", 32'(dir), 32'd1);
        check("rev_zero_ready", 32'(bus.target_ready), 32'd1);
`endif
        tick_expect("rev_up_3", 4'd3);
        tick_expect("rev_up_5", 4'd5);
        check("rev_done_ready", 32'(bus.target_ready), 32'd1);
        check("rev_done_busy", 32'(busy), 32'd0);

        // Saturation at the top of range
        next_tick();
        send(4'd13, 1'b1);
        tick_expect("sat_8", 4'd8);
        tick_expect("sat_11", 4'd11);
        tick_expect("sat_13", 4'd13);
        next_tick();
        send(4'd15, 1'b1);
        tick_expect("sat_15", 4'd15);
        check("sat_busy", 32'(busy), 32'd0);
        tick_expect("sat_no_wrap", 4'd15);

        // Acceptance on a tick cycle slews toward the old target
        next_tick();
        send(4'd3, 1'b1);
        tick_expect("old_tgt_12", 4'd12);
        send_on_tick(4'd12, 1'b1);
        check("old_tgt_9", 32'(compare), 32'd9);
        check("old_tgt_busy", 32'(busy), 32'd1);

        // Estop at 9 in TRACK
        estop = 1'b1;
        @(posedge clk);
        #1;
        check("estop_compare", 32'(compare), 32'd0);
        check("estop_busy", 32'(busy), 32'd0);
        check("estop_ready", 32'(bus.target_ready), 32'd0);
        check("estop_dir", 32'(dir), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("estop_held_compare", 32'(compare), 32'd0);
        check("estop_held_ready", 32'(bus.target_ready), 32'd0);
        estop = 1'b0;
        #1;
        check("estop_release_ready", 32'(bus.target_ready), 32'd1);

        // Target equal to compare: settles with no compare change
        next_tick();
        send(4'd0, 1'b0);
        check("eq_dir", 32'(dir), 32'd0);
        check("eq_busy", 32'(busy), 32'd1);
        tick_expect("eq_compare", 4'd0);
        check("eq_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-ramp
        next_tick();
        send(4'd10, 1'b0);
        tick_expect("ar_3", 4'd3);
        tick_expect("ar_6", 4'd6);
        #3;
        rst = 1'b0;
        #1;
        check("ar_compare", 32'(compare), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (period_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check("ar_first_tick", 32'(seen), 32'd1);
        gap = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gap++;
            if (period_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check("ar_tick_period", 32'(gap), 32'd16);
        check("ar_idle_compare", 32'(compare), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
